mult_seq_unit: RTL and testbench

Iterative shift-and-add multiplier for the KGP-RISC execute stage. It takes two 32-bit register operands and returns a 64-bit product as `hi`/`lo` words. The product is computed over a fixed multi-cycle latency. Its `lo` (or `hi`) output feeds the writeback 2:1 result select alongside the ALU result; the control unit stalls the pipeline while `busy` is high.

---
 rtl/mult_seq_unit_if.sv | 24 ++
 rtl/mult_seq_unit.sv | 129 ++++++++++++
 tb/tb_mult_seq_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mult_seq_unit_if.sv
// Request/result bundle between the execute-stage control and the sequential multiplier.
// The master drives operands and start; the slave returns status and product.
interface mult_seq_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_seq_unit.sv
// Iterative shift-and-add multiplier: sign-magnitude operands, WIDTH add/shift steps,
// then a sign-fix cycle that publishes the 2*WIDTH-bit product on hi/lo.
module mult_seq_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  mult_seq_unit_if.slave mul
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              neg_q, neg_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;

  logic [WIDTH:0]    upper_c;
  logic [PW-1:0]     prod_c;

  // Magnitude of a two's-complement value when signed mode applies; raw value otherwise.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn & v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (mul.start) state_d = S_RUN;
      S_RUN:  if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      S_FIX:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    busy_d   = (state_d != S_IDLE);
    upper_c  = {1'b0, acc_q[PW-1:WIDTH]};
    prod_c   = neg_q ? (~acc_q + PW'(1)) : acc_q;

    unique case (state_q)
      S_IDLE: begin
        if (mul.start) begin
          neg_d    = mul.is_signed & (mul.a[WIDTH-1] ^ mul.b[WIDTH-1]);
          mcand_d  = magnitude(mul.a, mul.is_signed);
          mplier_d = magnitude(mul.b, mul.is_signed);
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      S_RUN: begin
        // Carry out of the add lands in the accumulator MSB after the shift.
        if (mplier_q[0]) upper_c = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, mcand_q};
        acc_d    = {upper_c, acc_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
      end
      S_FIX: begin
        hi_d   = prod_c[PW-1:WIDTH];
        lo_d   = prod_c[WIDTH-1:0];
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign mul.busy = busy_q;
  assign mul.done = done_q;
  assign mul.hi   = hi_q;
  assign mul.lo   = lo_q;

endmodule

// File: tb/tb_mult_seq_unit.sv
// Self-checking bench for mult_seq_unit: directed corner cases plus randomized operands
// compared against a 64-bit arithmetic reference product.
module tb_mult_seq_unit;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  mult_seq_unit_if #(.WIDTH(W)) mif ();

  mult_seq_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .mul (mif)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint sx;
    longint sy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    return 64'(x) * 64'(y);
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Present a request now; the next rising edge is the accept edge.
  task automatic drive_start(input logic [31:0] x, input logic [31:0] y, input logic s);
    mif.start = 1'b1; mif.a = x; mif.b = y; mif.is_signed = s;
    @(posedge clk); #1;
    mif.start = 1'b0; mif.a = $urandom; mif.b = $urandom; mif.is_signed = 1'($urandom);
  endtask

  task automatic launch(input logic [31:0] x, input logic [31:0] y, input logic s);
    @(negedge clk);
    drive_start(x, y, s);
  endtask

  // Wait (bounded) for done; lat counts accept-relative edges, held tracks hi/lo stability.
  task automatic wait_done(input int elapsed, output int lat, output int bcnt, output bit held);
    logic [63:0] prev;
    prev = {mif.hi, mif.lo};
    lat  = elapsed;
    bcnt = 0;
    held = 1'b1;
    for (int k = 0; k < 80; k++) begin
      if (mif.busy) bcnt++;
      @(posedge clk); #1;
      lat++;
      if (mif.done) break;
      if ({mif.hi, mif.lo} !== prev) held = 1'b0;
    end
  endtask

  task automatic run_check(input string tag, input logic [31:0] x, input logic [31:0] y, input logic s);
    int lat, bcnt;
    bit held;
    launch(x, y, s);
    wait_done(0, lat, bcnt, held);
    chk({tag, "_latency"}, 64'(lat), 64'd33);
    chk({tag, "_busy_cycles"}, 64'(bcnt), 64'd33);
    chk({tag, "_busy_low_at_done"}, 64'(mif.busy), 64'd0);
    chk({tag, "_hold"}, 64'(held), 64'd1);
    chk({tag, "_product"}, {mif.hi, mif.lo}, ref_mul(x, y, s));
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 64'(mif.done), 64'd0);
  endtask

  initial begin
    int lat, bcnt, ndone, nbusy;
    bit held;
    logic [31:0] x, y;
    logic s;

    mif.start = 1'b0; mif.is_signed = 1'b0; mif.a = '0; mif.b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {30'd0, mif.busy, mif.done, mif.hi, mif.lo}, 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_reset", {62'd0, mif.busy, mif.done}, 64'd0);

    run_check("u7x9", 32'd7, 32'd9, 1'b0);
    chk("u7x9_lo_const", {mif.hi, mif.lo}, 64'h0000_0000_0000_003F);
    run_check("s_m3x5", 32'hFFFF_FFFD, 32'd5, 1'b1);
    chk("s_m3x5_const", {mif.hi, mif.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_check("s_min_sq", 32'h8000_0000, 32'h8000_0000, 1'b1);
    chk("s_min_sq_const", {mif.hi, mif.lo}, 64'h4000_0000_0000_0000);
    run_check("u_max_sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("u_max_sq_const", {mif.hi, mif.lo}, 64'hFFFF_FFFE_0000_0001);
    run_check("s_m1_sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    chk("s_m1_sq_const", {mif.hi, mif.lo}, 64'h0000_0000_0000_0001);

    // A second start ten cycles into a multiply is dropped.
    launch(32'd6, 32'd7, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    drive_start(32'd100, 32'd100, 1'b0);
    wait_done(10, lat, bcnt, held);
    chk("busy_start_latency", 64'(lat), 64'd33);
    chk("busy_start_product", {mif.hi, mif.lo}, 64'd42);
    ndone = 0;
    repeat (40) begin @(posedge clk); #1; if (mif.done) ndone++; end
    chk("busy_start_no_second_done", 64'(ndone), 64'd0);

    // Start issued in the done cycle is accepted immediately.
    launch(32'd4, 32'd5, 1'b0);
    wait_done(0, lat, bcnt, held);
    chk("b2b_first_latency", 64'(lat), 64'd33);
    chk("b2b_first_product", {mif.hi, mif.lo}, 64'd20);
    drive_start(32'd2, 32'd3, 1'b0);
    wait_done(0, lat, bcnt, held);
    chk("b2b_second_spacing", 64'(lat + 1), 64'd34);
    chk("b2b_second_product", {mif.hi, mif.lo}, 64'd6);

    // Asynchronous reset in the middle of a multiply.
    launch(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    repeat (14) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_outputs", {30'd0, mif.busy, mif.done, mif.hi, mif.lo}, 64'd0);
    @(negedge clk); rst = 1'b0;
    ndone = 0; nbusy = 0;
    repeat (40) begin @(posedge clk); #1; if (mif.done) ndone++; if (mif.busy) nbusy++; end
    chk("rst_mid_no_done", 64'(ndone), 64'd0);
    chk("rst_mid_no_busy", 64'(nbusy), 64'd0);
    run_check("post_rst_3x3", 32'd3, 32'd3, 1'b0);
    chk("post_rst_3x3_const", {mif.hi, mif.lo}, 64'd9);

    for (int i = 0; i < 24; i++) begin
      x = pick();
      y = pick();
      s = 1'($urandom);
      run_check($sformatf("rand%0d", i), x, y, s);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
